buffer_crossbar_pipe: RTL

//  Parametrised, pipelined, bidirectional crossbar between NUM_SRC buffer RAMs and NUM_DST NTT modules.

---
 rtl/buffer_crossbar_pipe_if.sv | 44 ++++
 rtl/buffer_crossbar_pipe.sv | 136 +++++++++++++
 2 files changed

// File: rtl/buffer_crossbar_pipe_if.sv
// buffer_crossbar_pipe_if: routing bus of the RAM <-> NTT crossbar.
// master drives requests and source data; slave is the crossbar itself.
interface buffer_crossbar_pipe_if #(
    parameter int DATA_SIZE = 512,
    parameter int ADDR_W    = 16,
    parameter int NUM_SRC   = 20,
    parameter int NUM_DST   = 20
);
    localparam int SEL_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;

    // wren is the last field, so it sits in bit 0 of the packed bundle
    typedef struct packed {
        logic [ADDR_W-1:0]    waddr;
        logic [DATA_SIZE-1:0] wdata;
        logic                 wren;
    } ram_in_t;

    logic                 stall_i;
    logic                 err_clr_i;
    logic [DATA_SIZE-1:0] ram_outputs_i [NUM_SRC];
    ram_in_t              module_outputs_i [NUM_SRC];
    logic [SEL_W-1:0]     fwd_sel_i [NUM_DST];
    logic [SEL_W-1:0]     wr_sel_i [NUM_DST];
    logic [NUM_DST-1:0]   fwd_vld_i;
    logic [NUM_DST-1:0]   wr_vld_i;
    logic [DATA_SIZE-1:0] module_inputs_o [NUM_DST];
    logic [NUM_DST-1:0]   module_vld_o;
    ram_in_t              ram_inputs_o [NUM_DST];
    logic [NUM_DST-1:0]   ram_vld_o;
    logic [2*NUM_DST-1:0] sel_err_o;
    logic                 busy_o;

    modport master (
        output stall_i, err_clr_i, ram_outputs_i, module_outputs_i,
               fwd_sel_i, wr_sel_i, fwd_vld_i, wr_vld_i,
        input  module_inputs_o, module_vld_o, ram_inputs_o, ram_vld_o, sel_err_o, busy_o
    );

    modport slave (
        input  stall_i, err_clr_i, ram_outputs_i, module_outputs_i,
               fwd_sel_i, wr_sel_i, fwd_vld_i, wr_vld_i,
        output module_inputs_o, module_vld_o, ram_inputs_o, ram_vld_o, sel_err_o, busy_o
    );
endinterface

// File: rtl/buffer_crossbar_pipe.sv
// buffer_crossbar_pipe: pipelined bidirectional crossbar between buffer RAMs and NTT modules,
// one log2 mux tree per destination with its select and valid riding along with the data.
module buffer_crossbar_pipe_tree #(
    parameter int W         = 512,
    parameter int NUM_SRC   = 20,
    parameter int SEL_W     = 5,
    parameter int REG_EVERY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_i,
    input  logic [W-1:0]     src_i [NUM_SRC],
    input  logic [SEL_W-1:0] sel_i,
    input  logic             vld_i,
    output logic [W-1:0]     dat_o,
    output logic             vld_o,
    output logic             busy_o,
    output logic             bad_o
);
    localparam int LEVELS = SEL_W;

    logic [LEVELS:0] busy_v;

    assign bad_o = vld_i && ({1'b0, sel_i} >= (SEL_W+1)'(NUM_SRC));

    for (genvar l = 0; l <= LEVELS; l++) begin : lv
        localparam int N = 2 ** (LEVELS - l);
        logic [W-1:0]     r [N];
        logic [SEL_W-1:0] s;
        logic             v;
        if (l == 0) begin : g
            // out-of-range requests travel as all-zero data, wren included
            for (genvar n = 0; n < N; n++) begin : m
                if (n < NUM_SRC) begin : a
                    assign r[n] = bad_o ? '0 : src_i[n];
                end else begin : z
                    assign r[n] = '0;
                end
            end
            assign s         = sel_i;
            assign v         = vld_i;
            assign busy_v[l] = 1'b0;
        end else begin : g
            logic [W-1:0] r_d [N];
            for (genvar n = 0; n < N; n++) begin : m
                assign r_d[n] = lv[l-1].s[l-1] ? lv[l-1].r[2*n+1] : lv[l-1].r[2*n];
            end
            if (l % REG_EVERY == 0 || l == LEVELS) begin : q
                logic [W-1:0]     r_q [N];
                logic [SEL_W-1:0] s_q;
                logic             v_q;
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_q <= '{default: '0};
                        s_q <= '0;
                        v_q <= 1'b0;
                    end else if (!stall_i) begin
                        r_q <= r_d;
                        s_q <= lv[l-1].s;
                        v_q <= lv[l-1].v;
                    end
                end
                assign r         = r_q;
                assign s         = s_q;
                assign v         = v_q;
                assign busy_v[l] = v_q;
            end else begin : c
                assign r         = r_d;
                assign s         = lv[l-1].s;
                assign v         = lv[l-1].v;
                assign busy_v[l] = 1'b0;
            end
        end
    end

    assign dat_o  = lv[LEVELS].r[0];
    assign vld_o  = lv[LEVELS].v;
    assign busy_o = |busy_v;
endmodule

module buffer_crossbar_pipe #(
    parameter int DATA_SIZE = 512,
    parameter int ADDR_W    = 16,
    parameter int NUM_SRC   = 20,
    parameter int NUM_DST   = 20,
    parameter int REG_EVERY = 1
) (
    input logic clk,
    input logic rst,
    buffer_crossbar_pipe_if.slave bus
);
    localparam int SEL_W = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    localparam int BW    = ADDR_W + DATA_SIZE + 1;

    logic [BW-1:0]        wsrc [NUM_SRC];
    logic [BW-1:0]        wdst [NUM_DST];
    logic [2*NUM_DST-1:0] bad;
    logic [2*NUM_DST-1:0] busy_v;
    logic [2*NUM_DST-1:0] err_d;
    logic [2*NUM_DST-1:0] err_q;

    for (genvar s = 0; s < NUM_SRC; s++) begin : src
        assign wsrc[s] = bus.module_outputs_i[s];
    end

    for (genvar d = 0; d < NUM_DST; d++) begin : dst
        buffer_crossbar_pipe_tree #(
            .W(DATA_SIZE), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .REG_EVERY(REG_EVERY)
        ) u_fwd (
            .clk(clk), .rst(rst), .stall_i(bus.stall_i),
            .src_i(bus.ram_outputs_i), .sel_i(bus.fwd_sel_i[d]), .vld_i(bus.fwd_vld_i[d]),
            .dat_o(bus.module_inputs_o[d]), .vld_o(bus.module_vld_o[d]),
            .busy_o(busy_v[d]), .bad_o(bad[d])
        );
        buffer_crossbar_pipe_tree #(
            .W(BW), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .REG_EVERY(REG_EVERY)
        ) u_wr (
            .clk(clk), .rst(rst), .stall_i(bus.stall_i),
            .src_i(wsrc), .sel_i(bus.wr_sel_i[d]), .vld_i(bus.wr_vld_i[d]),
            .dat_o(wdst[d]), .vld_o(bus.ram_vld_o[d]),
            .busy_o(busy_v[NUM_DST+d]), .bad_o(bad[NUM_DST+d])
        );
        // a stale bundle must never write the RAM
        assign bus.ram_inputs_o[d] = {wdst[d][BW-1:1], wdst[d][0] & bus.ram_vld_o[d]};
    end

    assign err_d = (bus.err_clr_i ? '0 : err_q) | (bad & {2*NUM_DST{~bus.stall_i}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= '0;
        else     err_q <= err_d;
    end

    assign bus.sel_err_o = err_q;
    assign bus.busy_o    = |busy_v;
endmodule
